pong_game_ctrl: RTL



---
 rtl/pong_pkg.sv | 41 ++++
 rtl/pong_game_ctrl_if.sv | 42 ++++
 rtl/pong_game_ctrl_frame_timer.sv | 50 +++++
 rtl/pong_game_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Types and constants shared by the Pong match controller and the blocks it
// sequences: state encodings and enum, side identifiers, the default
// winning score and screen geometry used by the paddle and ball blocks.
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int DEFAULT_WIN_SCORE = 7;

  localparam int SCREEN_H        = 480;
  localparam int PADDLE_Y_CENTRE = SCREEN_H / 2;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SERVE = ST_SERVE,
    S_PLAY  = ST_PLAY,
    S_POINT = ST_POINT,
    S_OVER  = ST_OVER
  } state_t;

  // States in which a rally is in progress (pause is allowed here).
  function automatic logic in_game(state_t s);
    return (s == S_SERVE) || (s == S_PLAY) || (s == S_POINT);
  endfunction

  // States that wait on the frame timer.
  function automatic logic is_timed(state_t s);
    return (s == S_SERVE) || (s == S_POINT);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl_if
// Signal bundle between the match controller and its surroundings.
//   Inputs to the controller : frame_tick, start_btn, pause_btn,
//                              miss_left, miss_right
//   Outputs of the controller: paddle_en, paddle_rst, ball_en, ball_rst,
//                              serve_dir, score_l, score_r, game_over,
//                              winner, state
// Modports: master = the environment (drives inputs, observes outputs),
//           slave  = the controller.
// ---------------------------------------------------------------------------
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               miss_left;
  logic               miss_right;
  logic               paddle_en;
  logic               paddle_rst;
  logic               ball_en;
  logic               ball_rst;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start_btn, pause_btn, miss_left, miss_right,
    input  paddle_en, paddle_rst, ball_en, ball_rst, serve_dir,
           score_l, score_r, game_over, winner, state
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, miss_left, miss_right,
    output paddle_en, paddle_rst, ball_en, ball_rst, serve_dir,
           score_l, score_r, game_over, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Counts frame ticks after a load and pulses done on the target-th tick.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : restart counting from zero (wins over a coincident tick)
//   hold         : freeze the count, ignore ticks
//   tick         : one-cycle frame pulse
//   target       : number of ticks to count (>= 1)
//   done         : combinational one-cycle pulse on the target-th tick
// done does not depend on load so the owner can derive load from a
// next-state decision that itself uses done.
// ---------------------------------------------------------------------------
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             hold,
  input  logic             tick,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             last_tick;

  assign last_tick = (count_reg == target - CNT_W'(1));
  assign done      = tick && !hold && last_tick;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = '0;
    end else if (tick && !hold) begin
      count_next = last_tick ? '0 : count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Match sequencer for the Pong datapath: gates/resets paddles and ball,
// keeps the score and steps IDLE -> SERVE -> PLAY -> POINT -> OVER at frame
// pace.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset, highest priority
//   bus      : pong_game_ctrl_if.slave (frame_tick, start/pause buttons,
//              miss pulses in; enables, reset pulses, serve direction,
//              scores, game_over, winner, state out -- all registered)
// Optional build macro: PONG_PAUSE_EN adds a pause toggle driven by
// pause_btn rising edges during SERVE/PLAY/POINT. Without it pause_btn is
// ignored.
// ---------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  pong_game_ctrl_if.slave   bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t state_reg, state_next;

  logic start_q_reg;
  logic start_edge;
  logic paused_reg, paused_next;

  logic paddle_en_reg, paddle_en_next;
  logic ball_en_reg,   ball_en_next;
  logic rst_pulse_reg, rst_pulse_next;
  logic serve_dir_reg, serve_dir_next;
  logic game_over_reg, game_over_next;
  logic winner_reg,    winner_next;

  logic             timer_load;
  logic             timer_hold;
  logic             timer_done;
  logic [CNT_W-1:0] timer_target;

  logic             live;
  logic [1:0]       score_inc;   // index 0 = left player, 1 = right player
  logic             score_clr;
  logic [SCORE_W-1:0] score_l, score_r;
  logic             win_l, win_r;

  // -------------------------------------------------------------------------
  // Start edge detection. The history bit follows the button even during
  // reset, so a button held through reset is seen as already pressed and
  // only a release-and-press starts a game. With the button released during
  // reset it reads 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    start_q_reg <= bus.start_btn;
  end

  assign start_edge = bus.start_btn & ~start_q_reg;

  // -------------------------------------------------------------------------
  // Optional pause
  // -------------------------------------------------------------------------
`ifdef PONG_PAUSE_EN
  logic pause_q_reg;
  logic pause_edge;

  always_ff @(posedge clk) begin
    pause_q_reg <= bus.pause_btn;
  end

  assign pause_edge = bus.pause_btn & ~pause_q_reg;

  always_comb begin
    paused_next = paused_reg;
    if (state_next == S_IDLE || state_next == S_OVER) begin
      paused_next = 1'b0;
    end else if (pause_edge && in_game(state_reg)) begin
      paused_next = ~paused_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      paused_reg <= 1'b0;
    end else begin
      paused_reg <= paused_next;
    end
  end
`else
  logic pause_unused;
  assign pause_unused = bus.pause_btn;
  assign paused_reg   = 1'b0;
  assign paused_next  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Frame timer: restarted on every state change, so a tick coinciding with
  // the change is not counted by the new state.
  // -------------------------------------------------------------------------
  assign timer_load   = (state_next != state_reg);
  assign timer_hold   = paused_reg || !is_timed(state_reg);
  assign timer_target = (state_reg == S_POINT) ? CNT_W'(POINT_FRAMES)
                                               : CNT_W'(SERVE_FRAMES);

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .hold    (timer_hold),
    .tick    (bus.frame_tick),
    .target  (timer_target),
    .done    (timer_done)
  );

  // -------------------------------------------------------------------------
  // Score counters, one per side
  // -------------------------------------------------------------------------
  assign live         = (state_reg == S_PLAY) && !paused_reg;
  assign score_inc[0] = live &  bus.miss_right & ~bus.miss_left;
  assign score_inc[1] = live &  bus.miss_left  & ~bus.miss_right;
  assign score_clr    = (state_reg == S_OVER) && start_edge;

  for (genvar gi = 0; gi < 2; gi++) begin : g_score
    logic [SCORE_W-1:0] score_reg;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        score_reg <= '0;
      end else if (score_clr) begin
        score_reg <= '0;
      end else if (score_inc[gi] && (score_reg != WIN_VAL)) begin
        // Saturate at the winning score; POINT->OVER stops play before.
        score_reg <= score_reg + SCORE_W'(1);
      end
    end
  end

  assign score_l = g_score[0].score_reg;
  assign score_r = g_score[1].score_reg;
  assign win_l   = (score_l == WIN_VAL);
  assign win_r   = (score_r == WIN_VAL);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and next registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    serve_dir_next = serve_dir_reg;
    winner_next    = winner_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_edge) state_next = S_SERVE;
      end
      S_SERVE: begin
        if (timer_done) state_next = S_PLAY;
      end
      S_PLAY: begin
        if (live) begin
          if (bus.miss_left && bus.miss_right) begin
            // Simultaneous misses: nobody scores, replay the serve.
            state_next = S_SERVE;
          end else if (bus.miss_left) begin
            state_next     = S_POINT;
            serve_dir_next = SIDE_LEFT;
          end else if (bus.miss_right) begin
            state_next     = S_POINT;
            serve_dir_next = SIDE_RIGHT;
          end
        end
      end
      S_POINT: begin
        if (timer_done) begin
          if (win_l || win_r) begin
            state_next  = S_OVER;
            winner_next = win_r ? SIDE_RIGHT : SIDE_LEFT;
          end else begin
            state_next = S_SERVE;
          end
        end
      end
      S_OVER: begin
        if (start_edge) state_next = S_SERVE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    paddle_en_next = ((state_next == S_SERVE) || (state_next == S_PLAY)) && !paused_next;
    ball_en_next   = (state_next == S_PLAY) && !paused_next;
    rst_pulse_next = (state_next == S_SERVE) && (state_reg != S_SERVE);
    game_over_next = (state_next == S_OVER);
  end

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      paddle_en_reg <= 1'b0;
      ball_en_reg   <= 1'b0;
      rst_pulse_reg <= 1'b0;
      serve_dir_reg <= SIDE_RIGHT;
      game_over_reg <= 1'b0;
      winner_reg    <= SIDE_LEFT;
    end else begin
      paddle_en_reg <= paddle_en_next;
      ball_en_reg   <= ball_en_next;
      rst_pulse_reg <= rst_pulse_next;
      serve_dir_reg <= serve_dir_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign bus.paddle_en  = paddle_en_reg;
  assign bus.paddle_rst = rst_pulse_reg;
  assign bus.ball_en    = ball_en_reg;
  assign bus.ball_rst   = rst_pulse_reg;
  assign bus.serve_dir  = serve_dir_reg;
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.game_over  = game_over_reg;
  assign bus.winner     = winner_reg;
  assign bus.state      = state_reg;

endmodule
